// File: rtl/bus_pkg.sv
// Shared types and default memory map for the data-side bus controller.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } bus_state_e;

    // Default memory map of the micro_riscv platform
    localparam logic [31:0] MEM_START    = 32'h0000_0000;
    localparam logic [31:0] MEM_SIZE     = 32'h0001_0000;
    localparam logic [31:0] STDIN_START  = 32'h1000_0000;
    localparam logic [31:0] STDIN_SIZE   = 32'h0000_0004;
    localparam logic [31:0] STDOUT_START = 32'h2000_0000;
    localparam logic [31:0] STDOUT_SIZE  = 32'h0000_0004;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: one-hot slot select plus hit flag.
// Regions are compared in ADDR_W+1 bits so a region ending at the top of
// the address space does not wrap; overlapping regions resolve to the
// lowest slot index; a zero-sized slot never matches.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {STDOUT_START, STDIN_START, MEM_START},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_SIZE = {STDOUT_SIZE, STDIN_SIZE, MEM_SIZE}
) (
    input  logic [ADDR_W-1:0]     addr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  hit_o
);

    // Priority search from slot 0 upward; the first match locks out the rest
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (!hit_o
                && (SLV_SIZE[k*ADDR_W +: ADDR_W] != '0)
                && ({1'b0, addr_i} >= {1'b0, SLV_BASE[k*ADDR_W +: ADDR_W]})
                && ({1'b0, addr_i} <  ({1'b0, SLV_BASE[k*ADDR_W +: ADDR_W]}
                                     + {1'b0, SLV_SIZE[k*ADDR_W +: ADDR_W]}))) begin
                sel_o[k] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_bus_ctrl.sv
// Registered, handshaked data-bus controller between the CPU data port and
// N memory-mapped slaves, with wait states, timeout and error capture.
module data_bus_ctrl
    import bus_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {STDOUT_START, STDIN_START, MEM_START},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_SIZE = {STDOUT_SIZE, STDIN_SIZE, MEM_SIZE},
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         cpu_req_i,
    input  logic                         cpu_we_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W-1:0]            cpu_wdata_i,
    output logic                         cpu_ready_o,
    output logic [DATA_W-1:0]            cpu_rdata_o,
    output logic                         cpu_err_o,
    output logic [NUM_SLAVES-1:0]        slv_sel_o,
    output logic                         slv_re_o,
    output logic                         slv_we_o,
    output logic [ADDR_W-1:0]            slv_addr_o,
    output logic [DATA_W-1:0]            slv_wdata_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i,
    input  logic [NUM_SLAVES-1:0]        slv_ready_i,
    output logic                         err_valid_o,
    output logic [ADDR_W-1:0]            err_addr_o,
    input  logic                         err_clear_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bus_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    err_valid_q, err_valid_d;
    logic [ADDR_W-1:0]       err_addr_q, err_addr_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_hit;
    logic [DATA_W-1:0]       rdata_mux;

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_SIZE   (SLV_SIZE)
    ) u_decode (
        .addr_i (cpu_addr_i),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    // Pick the read data of the currently selected slot
    always_comb begin
        rdata_mux = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q[k]) begin
                rdata_mux = rdata_mux | slv_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic; sel_q is cleared on the cycle the counter expires,
    // so the strobes are already low during the final ACCESS cycle that
    // hands over to ERR.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;

        if (err_clear_i) begin
            err_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    addr_d  = cpu_addr_i;
                    wdata_d = cpu_wdata_i;
                    we_d    = cpu_we_i;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        sel_d   = dec_sel;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d = ST_ERR;
                end else if ((sel_q & slv_ready_i) != '0) begin
                    rdata_d = we_q ? '0 : rdata_mux;
                    sel_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                        sel_d = '0;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                // A set coinciding with a clear wins and reloads the address
                if (!err_valid_q || err_clear_i) begin
                    err_addr_d = addr_q;
                end
                err_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign slv_sel_o   = sel_q;
    assign slv_re_o    = (|sel_q) & ~we_q;
    assign slv_we_o    = (|sel_q) & we_q;
    assign slv_addr_o  = addr_q;
    assign slv_wdata_o = wdata_q;
    assign cpu_ready_o = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign cpu_err_o   = (state_q == ST_ERR);
    assign cpu_rdata_o = (state_q == ST_RESP) ? rdata_q : '0;
    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed self-checking bench for data_bus_ctrl.
module tb_data_bus_ctrl;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req = 1'b0;
    logic            we = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   wdata = '0;
    logic            ready_o;
    logic [DW-1:0]   rdata_o;
    logic            err_o;
    logic [NS-1:0]   sel_o;
    logic            re_o;
    logic            swe_o;
    logic [AW-1:0]   saddr_o;
    logic [DW-1:0]   swdata_o;
    logic [NS*DW-1:0] srdata = '0;
    logic [NS-1:0]   sready = '0;
    logic            evalid_o;
    logic [AW-1:0]   eaddr_o;
    logic            eclear = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_bus_ctrl #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SLV_BASE   ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_SIZE   ({32'h0000_0004, 32'h0000_0004, 32'h0000_1000}),
        .TIMEOUT    (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .cpu_req_i   (req),
        .cpu_we_i    (we),
        .cpu_addr_i  (addr),
        .cpu_wdata_i (wdata),
        .cpu_ready_o (ready_o),
        .cpu_rdata_o (rdata_o),
        .cpu_err_o   (err_o),
        .slv_sel_o   (sel_o),
        .slv_re_o    (re_o),
        .slv_we_o    (swe_o),
        .slv_addr_o  (saddr_o),
        .slv_wdata_o (swdata_o),
        .slv_rdata_i (srdata),
        .slv_ready_i (sready),
        .err_valid_o (evalid_o),
        .err_addr_o  (eaddr_o),
        .err_clear_i (eclear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ready"}, {31'd0, ready_o}, 32'd0);
        chk({tag, ".err"},   {31'd0, err_o},   32'd0);
        chk({tag, ".rdata"}, rdata_o,          32'd0);
        chk({tag, ".sel"},   {29'd0, sel_o},   32'd0);
        chk({tag, ".re"},    {31'd0, re_o},    32'd0);
        chk({tag, ".we"},    {31'd0, swe_o},   32'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step();
        step();
        chk_quiet("rst");
        chk("rst.saddr",  saddr_o,            32'd0);
        chk("rst.swdata", swdata_o,           32'd0);
        chk("rst.evalid", {31'd0, evalid_o},  32'd0);
        chk("rst.eaddr",  eaddr_o,            32'd0);
        rst = 1'b0;
        step();

        // Zero-wait read of slave 0
        sready = 3'b001;
        srdata[31:0] = 32'hDEAD_BEEF;
        addr = 32'h0000_0010; we = 1'b0; req = 1'b1;
        step();
        chk("rd0.c1.sel",   {29'd0, sel_o},  32'd1);
        chk("rd0.c1.re",    {31'd0, re_o},   32'd1);
        chk("rd0.c1.ready", {31'd0, ready_o}, 32'd0);
        chk("rd0.c1.saddr", saddr_o,         32'h0000_0010);
        step();
        chk("rd0.c2.ready", {31'd0, ready_o}, 32'd1);
        chk("rd0.c2.rdata", rdata_o,         32'hDEAD_BEEF);
        chk("rd0.c2.err",   {31'd0, err_o},  32'd0);
        chk("rd0.c2.sel",   {29'd0, sel_o},  32'd0);
        req = 1'b0; sready = 3'b000;
        step();
        chk_quiet("rd0.c3");

        // Write to slave 2 with two wait cycles
        addr = 32'h2000_0000; we = 1'b1; wdata = 32'h41; req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            chk($sformatf("wr2.c%0d.sel", c),   {29'd0, sel_o},   32'd4);
            chk($sformatf("wr2.c%0d.we", c),    {31'd0, swe_o},   32'd1);
            chk($sformatf("wr2.c%0d.re", c),    {31'd0, re_o},    32'd0);
            chk($sformatf("wr2.c%0d.ready", c), {31'd0, ready_o}, 32'd0);
            if (c == 3) sready = 3'b100;
        end
        chk("wr2.wdata", swdata_o, 32'h41);
        step();
        chk("wr2.c4.ready", {31'd0, ready_o}, 32'd1);
        chk("wr2.c4.err",   {31'd0, err_o},   32'd0);
        chk("wr2.c4.rdata", rdata_o,          32'd0);
        chk("wr2.c4.re",    {31'd0, re_o},    32'd0);
        req = 1'b0; we = 1'b0; sready = 3'b000;
        step();

        // Unmapped read, then a second error that must not overwrite
        addr = 32'h3000_0000; req = 1'b1;
        step();
        chk("um1.c1.ready", {31'd0, ready_o}, 32'd1);
        chk("um1.c1.err",   {31'd0, err_o},   32'd1);
        chk("um1.c1.rdata", rdata_o,          32'd0);
        chk("um1.c1.sel",   {29'd0, sel_o},   32'd0);
        req = 1'b0;
        step();
        chk("um1.c2.ready",  {31'd0, ready_o},  32'd0);
        chk("um1.c2.evalid", {31'd0, evalid_o}, 32'd1);
        chk("um1.c2.eaddr",  eaddr_o,           32'h3000_0000);
        addr = 32'h4000_0000; req = 1'b1;
        step();
        chk("um2.c1.err", {31'd0, err_o}, 32'd1);
        req = 1'b0;
        step();
        chk("um2.c2.evalid", {31'd0, evalid_o}, 32'd1);
        chk("um2.c2.eaddr",  eaddr_o,           32'h3000_0000);

        // Timeout on slave 1 (ready held low)
        addr = 32'h1000_0000; req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("to.c%0d.sel", c),   {29'd0, sel_o},   32'd2);
            chk($sformatf("to.c%0d.re", c),    {31'd0, re_o},    32'd1);
            chk($sformatf("to.c%0d.ready", c), {31'd0, ready_o}, 32'd0);
        end
        step();
        chk_quiet("to.c5");
        step();
        chk("to.c6.ready", {31'd0, ready_o}, 32'd1);
        chk("to.c6.err",   {31'd0, err_o},   32'd1);
        chk("to.c6.sel",   {29'd0, sel_o},   32'd0);
        req = 1'b0;
        step();
        chk("to.c7.eaddr", eaddr_o, 32'h3000_0000);

        // Reset during the second ACCESS cycle
        addr = 32'h0000_0000; req = 1'b1;
        step();
        step();
        chk("rs.c2.sel", {29'd0, sel_o}, 32'd1);
        rst = 1'b1; req = 1'b0;
        step();
        chk_quiet("rs.c3");
        chk("rs.c3.evalid", {31'd0, evalid_o}, 32'd0);
        chk("rs.c3.eaddr",  eaddr_o,           32'd0);
        chk("rs.c3.saddr",  saddr_o,           32'd0);
        rst = 1'b0;
        sready = 3'b001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("rs.idle%0d.ready", c), {31'd0, ready_o}, 32'd0);
        end
        srdata[31:0] = 32'h1234_5678;
        addr = 32'h0000_0000; req = 1'b1;
        step();
        chk("rs.rd.c1.sel", {29'd0, sel_o}, 32'd1);
        step();
        chk("rs.rd.c2.ready", {31'd0, ready_o}, 32'd1);
        chk("rs.rd.c2.rdata", rdata_o,          32'h1234_5678);
        chk("rs.rd.c2.err",   {31'd0, err_o},   32'd0);
        req = 1'b0; sready = 3'b000;
        step();

        // First error after reset, then clear coinciding with a new error
        addr = 32'h3000_0000; req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("cl.pre.eaddr", eaddr_o, 32'h3000_0000);
        addr = 32'h5000_0000; req = 1'b1;
        step();
        chk("cl.c1.err", {31'd0, err_o}, 32'd1);
        req = 1'b0; eclear = 1'b1;
        step();
        eclear = 1'b0;
        chk("cl.c2.evalid", {31'd0, evalid_o}, 32'd1);
        chk("cl.c2.eaddr",  eaddr_o,           32'h5000_0000);

        // Plain clear
        eclear = 1'b1;
        step();
        eclear = 1'b0;
        chk("clr.evalid", {31'd0, evalid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Parametrised data-side bus controller between `micro_riscv`'s data port and N memory-mapped slaves (memory, stdin, stdout, future peripherals). It replaces fixed, zero-latency address selection with a registered, handshaked transaction engine. It adds per-slave wait states, a bus timeout, unmapped-address error responses and a sticky error-capture register. Instruction fetch is outside this block.

## Interface
Parameters:
- `NUM_SLAVES`, 3: number of slave slots; must be at least 1.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `SLV_BASE`, packed `NUM_SLAVES*ADDR_W`: base address per slot. Slot k occupies bits [k*ADDR_W +: ADDR_W]. Defaults: slot 0 = `MEM_START, slot 1 = `STDIN_START, slot 2 = `STDOUT_START.
- `SLV_SIZE`, packed `NUM_SLAVES*ADDR_W`: region size per slot in bytes. Defaults: `MEM_SIZE, `STDIN_SIZE, `STDOUT_SIZE. A size of 0 disables the slot.
- `TIMEOUT`, 16: maximum number of ACCESS cycles before a bus error; must be at least 1.

Ports:
- `clk_i`, in, 1: single clock, rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `cpu_req_i`, in, 1: transaction request. Held high, with address, data and direction stable, until `cpu_ready_o`.
- `cpu_we_i`, in, 1: 1 = write, 0 = read.
- `cpu_addr_i`, in, `ADDR_W`: byte address.
- `cpu_wdata_i`, in, `DATA_W`: write data.
- `cpu_ready_o`, out, 1: one-cycle completion pulse.
- `cpu_rdata_o`, out, `DATA_W`: read data, valid while `cpu_ready_o` is high.
- `cpu_err_o`, out, 1: error completion, valid with `cpu_ready_o`.
- `slv_sel_o`, out, `NUM_SLAVES`: one-hot slave select.
- `slv_re_o`, out, 1: read strobe, qualified by `slv_sel_o`.
- `slv_we_o`, out, 1: write strobe, qualified by `slv_sel_o`.
- `slv_addr_o`, out, `ADDR_W`: latched address.
- `slv_wdata_o`, out, `DATA_W`: latched write data.
- `slv_rdata_i`, in, `NUM_SLAVES*DATA_W`: per-slave read data, sampled while that slave's ready is high.
- `slv_ready_i`, in, `NUM_SLAVES`: per-slave completion. A slave may hold it high permanently for zero wait states.
- `err_valid_o`, out, 1: sticky error flag.
- `err_addr_o`, out, `ADDR_W`: address of the first error since the last clear.
- `err_clear_i`, in, 1: clears the sticky error flag.

## Operation
- States: IDLE, ACCESS, RESP, ERR.
- IDLE: when `cpu_req_i` is high, latch address, write data and direction, then decode.
  - Decode hit → ACCESS, with the hit slot registered one-hot.
  - No hit → ERR.
- Decode rule: slot k hits when `base_k <= addr < base_k + size_k`.
  - Comparison is done in `ADDR_W+1` bits, so a region ending at the top of the address space does not wrap.
  - `size_k == 0` never hits.
  - Overlapping regions: the lowest index wins.
- ACCESS: drive `slv_sel_o`, plus `slv_re_o` or `slv_we_o`, from registers.
  - Selected ready high → capture that slot's rdata (reads only), go to RESP.
  - Otherwise increment the timeout counter, width `$clog2(TIMEOUT+1)`.
  - Counter reaches `TIMEOUT` → ERR. The slave strobes drop on exit.
- RESP: `cpu_ready_o` = 1 and `cpu_err_o` = 0; `cpu_rdata_o` = captured data (0 for writes); then → IDLE.
- ERR: `cpu_ready_o` = 1, `cpu_err_o` = 1, `cpu_rdata_o` = 0; then → IDLE.
  - If `err_valid_o` is 0, set it and load `err_addr_o`.
  - Later errors do not overwrite `err_addr_o` until a clear.
- `err_clear_i` clears `err_valid_o`. If it coincides with ERR, the set wins and the new address loads.
- Strobes and `slv_sel_o` are 0 outside ACCESS. `slv_re_o` and `slv_we_o` are never high together.
- `cpu_req_i` is ignored outside IDLE.

## Timing
- Reset (synchronous, takes priority in any state, including mid-ACCESS): state = IDLE, timeout counter = 0. All outputs are 0, including `err_valid_o` and `err_addr_o`. A transaction interrupted by reset never completes.
- Zero-wait access: request sampled at edge 0; ACCESS during cycle 1; `cpu_ready_o` high during cycle 2. That is 2 cycles request-to-ready, and the next request can be sampled at edge 3.
- W wait cycles (ready low for W ACCESS cycles): latency is 2 + W, with W < `TIMEOUT`.
- Timeout: ERR is entered after exactly `TIMEOUT` ACCESS cycles with ready low. `cpu_ready_o` and `cpu_err_o` rise in cycle `TIMEOUT` + 2. A ready arriving in ACCESS cycle `TIMEOUT` (1-based) still completes normally.
- Unmapped access: `cpu_ready_o` and `cpu_err_o` are high in cycle 1.

## Structure
- Package `bus_pkg`: the state enum and the default base/size constants taken from `defines.vh`.
- Sub-module `bus_addr_decode`: purely combinational address-to-one-hot-plus-hit decoder with lowest-index priority, parametrised identically to this block.
- `riscv_core` instantiates `data_bus_ctrl`. Slave modules gain a ready output; existing slaves tie ready high.

## Test plan
Bench configuration: `NUM_SLAVES` = 3, bases 0x0, 0x1000_0000, 0x2000_0000, sizes 0x1000, 4, 4, `TIMEOUT` = 4.
- Read 0x0000_0010, slave 0 returns ready=1 and rdata=0xDEAD_BEEF → `cpu_ready_o` high in cycle 2, `cpu_rdata_o` = 0xDEAD_BEEF, `cpu_err_o` = 0.
- Write 0x2000_0000 with data 0x41, slave 2 ready after 2 cycles → `slv_we_o` and `slv_sel_o` = 3'b100 for 3 cycles, `cpu_ready_o` in cycle 4, `slv_re_o` never high.
- Read 0x3000_0000 (unmapped) → `cpu_ready_o` and `cpu_err_o` in cycle 1; `err_valid_o` = 1, `err_addr_o` = 0x3000_0000. A second error at 0x4000_0000 leaves `err_addr_o` unchanged.
- Read slave 1 with ready held low → error completion in cycle 6; `slv_sel_o` = 0 from cycle 5.
- Assert reset in the second ACCESS cycle → next cycle all outputs are 0 and no `cpu_ready_o` ever appears; a following read of 0x0 completes normally.
- Assert `err_clear_i` in the same cycle as a new ERR at 0x5000_0000 → `err_valid_o` stays 1 and `err_addr_o` = 0x5000_0000.
